// File: rtl/pmod_spi_pkg.sv
// Shared types and helpers for the pmod_spi_master SPI frame engine.
// Includes the frame state encoding, port-width helpers and PmodJSTK defaults.
package pmod_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    HOLD
  } state_e;

  localparam int JSTK_BYTES   = 5;
  localparam int JSTK_CLK_DIV = 750;

  function automatic int len_width(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

  // Phase counter must cover the 16 half-periods of a byte and every delay phase.
  function automatic int phase_width(input int setup_hp, input int gap_hp, input int hold_hp);
    int m;
    m = 16;
    if (setup_hp > m) m = setup_hp;
    if (gap_hp > m) m = gap_hp;
    if (hold_hp > m) m = hold_hp;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/pmod_spi_tick.sv
// SCLK half-period tick generator: counts 0..CLK_DIV-1 while enabled and
// fires tick_o on the wrap cycle; clr_i holds the count at zero.
module pmod_spi_tick #(
  parameter int CLK_DIV = 750
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/pmod_spi_master.sv
// Single-clock multi-byte SPI master (CPOL/CPHA, SS setup/hold, inter-byte gap).
// Optional board self-test path enabled by defining PMOD_SPI_LOOPBACK_EN.
module pmod_spi_master
  import pmod_spi_pkg::*;
#(
  parameter int CLK_DIV   = JSTK_CLK_DIV,
  parameter int MAX_BYTES = JSTK_BYTES,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter int SETUP_HP  = 2,   // SETUP_HP, GAP_HP and HOLD_HP must be >= 1
  parameter int GAP_HP    = 2,
  parameter int HOLD_HP   = 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          start,
  input  logic [len_width(MAX_BYTES)-1:0] len,
  input  logic [8*MAX_BYTES-1:0]        din,
  input  logic                          MISO,
`ifdef PMOD_SPI_LOOPBACK_EN
  input  logic                          loopback,
`endif
  output logic                          SS,
  output logic                          SCLK,
  output logic                          MOSI,
  output logic [8*MAX_BYTES-1:0]        dout,
  output logic                          busy,
  output logic                          done
);

  localparam int LEN_W = len_width(MAX_BYTES);
  localparam int PH_W  = phase_width(SETUP_HP, GAP_HP, HOLD_HP);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(15);

  state_e                 state_q;
  logic [PH_W-1:0]        ph_q;
  logic [LEN_W-1:0]       byte_q, len_q, len_eff;
  logic [7:0]             tx_q, rx_q, rx_d, rx_byte;
  logic [8*MAX_BYTES-1:0] rest_q, stage_q, dout_q;
  logic                   ss_q, sclk_q, mosi_q, busy_q, done_q, miso_q;
  logic                   tick, lb, serial_in;

`ifdef PMOD_SPI_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif

  pmod_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK   (CLK),
    .RESET (RESET),
    .en_i  (state_q != IDLE),
    .clr_i (state_q == IDLE),
    .tick_o(tick)
  );

  assign len_eff   = (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;
  assign serial_in = lb ? mosi_q : miso_q;
  assign rx_d      = {rx_q[6:0], serial_in};
  // With CPHA=0 the last sample precedes the final half-period, so rx_q is already complete.
  assign rx_byte   = CPHA ? rx_d : rx_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      ph_q    <= '0;
      byte_q  <= '0;
      len_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rest_q  <= '0;
      stage_q <= '0;
      dout_q  <= '0;
      ss_q    <= 1'b1;
      sclk_q  <= CPOL;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      miso_q <= MISO;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // done_q blocks a start landing on the done cycle itself.
          if (start && !done_q) begin
            if (len_eff == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= SETUP;
              busy_q  <= 1'b1;
              ss_q    <= 1'b0;
              ph_q    <= '0;
              byte_q  <= '0;
              len_q   <= len_eff;
              tx_q    <= din[7:0];
              rest_q  <= din >> 8;
              stage_q <= '0;
              rx_q    <= '0;
              if (!CPHA) mosi_q <= din[7];
            end
          end
        end
        SETUP: if (tick) begin
          if (ph_q == PH_W'(SETUP_HP - 1)) begin
            state_q <= SHIFT;
            ph_q    <= '0;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        SHIFT: if (tick) begin
          sclk_q <= ~sclk_q;
          ph_q   <= (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
          if (ph_q[0] == CPHA) begin
            rx_q <= rx_d;
          end else if (ph_q != PH_LAST) begin
            mosi_q <= CPHA ? tx_q[7] : tx_q[6];
            tx_q   <= tx_q << 1;
          end
          if (ph_q == PH_LAST) begin
            for (int k = 0; k < MAX_BYTES; k++) begin
              if (byte_q == LEN_W'(k)) stage_q[8*k +: 8] <= rx_byte;
            end
            if (byte_q + 1'b1 < len_q) begin
              state_q <= GAP;
              byte_q  <= byte_q + 1'b1;
              tx_q    <= rest_q[7:0];
              rest_q  <= rest_q >> 8;
              if (!CPHA) mosi_q <= rest_q[7];
            end else begin
              state_q <= HOLD;
            end
          end
        end
        GAP: if (tick) begin
          if (ph_q == PH_W'(GAP_HP - 1)) begin
            state_q <= SHIFT;
            ph_q    <= '0;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        HOLD: if (tick) begin
          if (ph_q == PH_W'(HOLD_HP - 1)) begin
            state_q <= IDLE;
            ph_q    <= '0;
            ss_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dout_q  <= stage_q;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Self-test keeps the pins inactive while the engine runs with unchanged timing.
  assign SS   = ss_q | lb;
  assign SCLK = lb ? CPOL : sclk_q;
  assign MOSI = mosi_q;
  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/pmod_spi_master.md
Name: pmod_spi_master

Overview:
- Parametrised single-clock SPI master replacing the fixed three-block joystick interface: clock divider, byte shifter and multi-byte frame controller in one block.
- Runs entirely on CLK using an internal SCLK tick enable; no derived clock is fed into logic.
- Supports CPOL/CPHA modes, a configurable frame length, SS setup/hold times and inter-byte gaps.
- Serves PmodJSTK (5-byte, mode 0) and other SPI Pmods from the top level.

Parameters:
- CLK_DIV, 750, CLK cycles per SCLK half-period (750 gives 66.67 kHz at 100 MHz); must be ≥2.
- MAX_BYTES, 5, maximum bytes per frame.
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- SETUP_HP, 2, half-periods between SS fall and first SCLK edge.
- GAP_HP, 2, half-periods of idle SCLK between bytes.
- HOLD_HP, 1, half-periods between last SCLK edge and SS rise.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- len  in  $clog2(MAX_BYTES+1)  frame length in bytes.
- din  in  8*MAX_BYTES  transmit bytes; byte k is din[8k+7:8k].
- MISO  in  1  serial data from slave.
- SS  out  1  slave select, active low.
- SCLK  out  1  serial clock.
- MOSI  out  1  serial data to slave.
- dout  out  8*MAX_BYTES  received bytes; byte k is dout[8k+7:8k].
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset values: SS=1, SCLK=CPOL, MOSI=0, dout=0, busy=0, done=0; state IDLE.
- Tick: half-period counter counts 0..CLK_DIV-1 and is active only outside IDLE. The tick fires on the count wrap and the counter restarts from 0 on each state entry.
- States and transitions:
  - IDLE: start=1 latches din and len. busy=1 and SS=0 from the next cycle. len=0 → done pulse next cycle, SS never asserted, dout unchanged. len>MAX_BYTES is clamped to MAX_BYTES.
  - SETUP: SETUP_HP ticks, then SHIFT. For CPHA=0, bit 7 of byte 0 is on MOSI from SS fall.
  - SHIFT: 16 half-periods per byte; SCLK toggles on each tick.
    - CPHA=0: sample MISO on leading edges, update MOSI on trailing edges.
    - CPHA=1: update MOSI on leading edges, sample on trailing edges.
    - Bits are MSB first. After 8 bits the received byte is written to staging byte k. Then GAP if bytes remain, else HOLD.
  - GAP: GAP_HP ticks with SCLK=CPOL, then SHIFT for byte k+1. MOSI is preloaded for CPHA=0.
  - HOLD: HOLD_HP ticks, then SS=1, dout←staging (unused bytes zero), done=1 for one cycle, busy=0, IDLE.
- dout is stable throughout a frame and changes only on the done cycle.
- Frame duration from the start cycle to the done cycle: 1 + CLK_DIV·(SETUP_HP + 16n + GAP_HP·(n−1) + HOLD_HP) cycles.
- Simultaneous events: start while busy is ignored and not queued. start on the done cycle is ignored; a new start is accepted from the following cycle.
- Reset mid-frame: outputs return to reset values immediately and asynchronously; no done pulse; partial data is discarded.
- MISO is registered once before use. The sample point is the registered value on the sampling tick; the ≥2-cycle half-period guarantees settling.

Optional Feature:
- Macro: PMOD_SPI_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the shifter samples internal MOSI instead of MISO, the SS and SCLK pins stay inactive (SS=1, SCLK=CPOL), and timing is unchanged. This is a board self-test path.
- Undefined: port absent; MISO is always used.

Decomposition:
- Package pmod_spi_pkg: state enumeration (IDLE, SETUP, SHIFT, GAP, HOLD), a width function for len, and JSTK constants (JSTK_BYTES=5, JSTK_CLK_DIV=750).
- One sub-module, pmod_spi_tick: half-period counter with clear and tick output, parametrised by CLK_DIV.
- The frame FSM and shifter stay in the top module.

Test Plan:
- Mode 0 joystick frame, CLK_DIV=4, MAX_BYTES=5: len=5, din={8'h00,8'h00,8'h00,8'h00,8'h83}, slave model returns A1 B2 C3 D4 E5.
  - MOSI carries 83 00 00 00 00.
  - dout = E5D4C3B2A1.
  - done occurs at cycle 1 + 4·(2+80+8+1) = 365.
- CPOL=1, CPHA=1, len=2, din bytes 5A, 3C, loopback slave: dout = 3C5A; SCLK idles high; MOSI changes only on falling edges.
- len=0 → done on the next cycle, SS stays 1, dout unchanged. len=7 with MAX_BYTES=5 → exactly 40 SCLK edges pairs, i.e. 5 bytes.
- start pulsed mid-frame and again on the done cycle → both ignored; exactly one frame occurs.
- RESET low during byte 2 → SS=1, SCLK=CPOL, busy=0 and dout=0 in the same cycle, no done pulse; a following frame completes correctly.
- PMOD_SPI_LOOPBACK_EN defined, loopback=1, din byte 96 → dout byte 96, SS pin constant 1.
